// File: rtl/kmc_npr_xfer.sv
// ---------------------------------------------------------------------------
// kmc_npr_xfer
//
// Bus-side NPR (DMA) transfer engine of the KMC11. It sits directly behind
// the NPR Control Register: a rising edge of the NPR request starts exactly
// one word or byte transfer. The engine requests the device bus, waits for
// the grant/acknowledge, and (for reads) waits for read data. The transfer
// then completes with a one-cycle done pulse. If the bus does not respond
// within NXMCYC cycles, the transfer ends with a non-existent-memory pulse
// instead. That pulse is raised together with done, so microcode can always
// clear NPRRQ on done.
//
// Parameters
//   NXMCYC     grant/ack/data timeout in clock cycles
//   AW         bus address width (16-bit offset + 2-bit extension)
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   kmcINIT    synchronous initialize, active-high (same clearing as rst)
//   nprREQ     NPR request level (NPRC bit 0); rising edge starts a transfer
//   nprOUT     1 = write to bus, 0 = read from bus
//   nprBYTE    byte transfer
//   nprBAEI    address extension for reads
//   nprBAEO    address extension for writes
//   kmcIBA     read bus address
//   kmcOBA     write bus address
//   kmcODAT    write data
//   busREQO    bus request
//   busACKI    bus grant/acknowledge
//   busDATVI   read data valid
//   busDATAI   bus read data
//   busADDRO   bus address (held for the whole transfer)
//   busWRO     write qualifier (held for the whole transfer)
//   busBYTEO   byte cycle (held for the whole transfer)
//   busDATAO   bus write data (held for the whole transfer)
//   kmcIDAT    captured read data
//   kmcNPRDONE one-cycle completion pulse (also raised on NXM)
//   kmcNXM     one-cycle non-existent-memory pulse
// ---------------------------------------------------------------------------
module kmc_npr_xfer #(
    parameter int NXMCYC = 200,
    parameter int AW     = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          kmcINIT,
    input  logic          nprREQ,
    input  logic          nprOUT,
    input  logic          nprBYTE,
    input  logic [1:0]    nprBAEI,
    input  logic [1:0]    nprBAEO,
    input  logic [15:0]   kmcIBA,
    input  logic [15:0]   kmcOBA,
    input  logic [15:0]   kmcODAT,
    output logic          busREQO,
    input  logic          busACKI,
    input  logic          busDATVI,
    input  logic [15:0]   busDATAI,
    output logic [AW-1:0] busADDRO,
    output logic          busWRO,
    output logic          busBYTEO,
    output logic [15:0]   busDATAO,
    output logic [15:0]   kmcIDAT,
    output logic          kmcNPRDONE,
    output logic          kmcNXM
);

    localparam int            CW         = $clog2(NXMCYC + 1);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(NXMCYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RDWT,
        ST_DONE,
        ST_NXM
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic           r_req_q;     // previous nprREQ, for rising-edge detect
    logic [CW-1:0]  r_cnt;       // cycles left before NXM
    logic [AW-1:0]  r_addr;
    logic           r_wr;
    logic           r_byte;
    logic [15:0]    r_dato;
    logic [15:0]    r_idat;

    logic           w_start;
    logic           w_latch;
    logic           w_cnt_load;
    logic           w_cnt_dec;
    logic           w_capture;
    logic           w_busreq;
    logic           w_done;
    logic           w_nxm;
    logic [AW-1:0]  w_addr_sel;
    logic [15:0]    w_dato_sel;
    logic [15:0]    w_rd_sel;

    // Only a rising edge starts a transfer. r_req_q tracks nprREQ in every
    // state, so a request held high through completion cannot retrigger.
    assign w_start = nprREQ & ~r_req_q;

    assign w_addr_sel = nprOUT ? AW'({nprBAEO, kmcOBA}) : AW'({nprBAEI, kmcIBA});
    assign w_dato_sel = nprBYTE ? {kmcODAT[7:0], kmcODAT[7:0]} : kmcODAT;

    // A byte read returns the addressed lane right-justified and zero-extended.
    assign w_rd_sel = r_byte ? {8'h00, (r_addr[0] ? busDATAI[15:8] : busDATAI[7:0])}
                             : busDATAI;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else if (kmcINIT) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        w_busreq    = 1'b0;
        w_done      = 1'b0;
        w_nxm       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_latch     = 1'b1;
                    w_cnt_load  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                w_busreq = 1'b1;
                // An ack arriving on the expiry cycle is tested first and wins.
                if (busACKI) begin
                    w_state_nxt = r_wr ? ST_DONE : ST_RDWT;
                end else if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_state_nxt = ST_NXM;
                end
            end

            ST_RDWT: begin
                // The timeout continues from where REQ left it, so the whole
                // transfer is bounded by NXMCYC, not each phase separately.
                w_busreq = 1'b1;
                if (busDATVI) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt != '0) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_state_nxt = ST_NXM;
                end
            end

            ST_DONE: begin
                w_done      = 1'b1;
                w_cnt_load  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            ST_NXM: begin
                w_done      = 1'b1;
                w_nxm       = 1'b1;
                w_cnt_load  = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timeout counter, transfer latches and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_q <= 1'b0;
            r_cnt   <= CNT_RELOAD;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_byte  <= 1'b0;
            r_dato  <= '0;
            r_idat  <= '0;
        end else if (kmcINIT) begin
            r_req_q <= 1'b0;
            r_cnt   <= CNT_RELOAD;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_byte  <= 1'b0;
            r_dato  <= '0;
            r_idat  <= '0;
        end else begin
            r_req_q <= nprREQ;

            // Loads and decrements are mutually exclusive by state, and a
            // decrement is only issued for a non-zero count: no wrap.
            if (w_cnt_load) begin
                r_cnt <= CNT_RELOAD;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_latch) begin
                r_addr <= w_addr_sel;
                r_wr   <= nprOUT;
                r_byte <= nprBYTE;
                r_dato <= w_dato_sel;
            end

            if (w_capture) begin
                r_idat <= w_rd_sel;
            end
        end
    end

    assign busREQO    = w_busreq;
    assign busADDRO   = r_addr;
    assign busWRO     = r_wr;
    assign busBYTEO   = r_byte;
    assign busDATAO   = r_dato;
    assign kmcIDAT    = r_idat;
    assign kmcNPRDONE = w_done;
    assign kmcNXM     = w_nxm;

endmodule
